// File: rtl/gpr_wb_ctrl.sv
// Register-file writeback controller: ALU results win the write port, LSU/MDU results
// queue in a small FIFO, and a busy scoreboard tracks in-flight destinations.
// Optional macro GPR_WB_BYPASS_EN lets an LSU result skip an empty FIFO.
module gpr_wb_ctrl #(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 64
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_wdata,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_rd,
  input  logic [XLEN-1:0]               lsu_wdata,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_rd,
  input  logic [4:0]                    rs1,
  input  logic [4:0]                    rs2,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic                          reg_wen,
  output logic [4:0]                    rd,
  output logic [XLEN-1:0]               rd_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   pending_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [4:0]      r_mem_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] r_mem_data [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_busy;
  logic            r_wen;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wdata;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_bypass;
  logic            w_enq;
  logic            w_sel_valid;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [31:0]     w_busy_next;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign lsu_ready   = !w_full;
  assign w_push      = lsu_valid && lsu_ready;
  assign w_pop       = !alu_valid && !w_empty;
  assign w_enq       = w_push && !w_bypass;
  assign pending_cnt = r_count;
  assign rs1_busy    = r_busy[rs1];
  assign rs2_busy    = r_busy[rs2];
  assign reg_wen     = r_wen;
  assign rd          = r_rd;
  assign rd_wdata    = r_wdata;

`ifdef GPR_WB_BYPASS_EN
  assign w_bypass = !alu_valid && w_empty && w_push;
`else
  assign w_bypass = 1'b0;
`endif

  // Write-port source select: ALU, then FIFO head, then (optionally) a bypassed LSU result.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rd    = r_rd;
    w_sel_data  = r_wdata;
    if (alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = alu_rd;
      w_sel_data  = alu_wdata;
    end else if (w_pop) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = r_mem_rd[r_rptr];
      w_sel_data  = r_mem_data[r_rptr];
    end else if (w_bypass) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = lsu_rd;
      w_sel_data  = lsu_wdata;
    end
  end

  // Clear is applied before set so an issue to the same register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop || w_bypass) begin
      w_busy_next[w_sel_rd] = 1'b0;
    end
    if (issue_valid) begin
      w_busy_next[issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_mem_rd[r_wptr]   <= lsu_rd;
      r_mem_data[r_wptr] <= lsu_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      r_wen   <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_busy  <= w_busy_next;
      r_wen   <= w_sel_valid && (w_sel_rd != 5'd0);
      r_rd    <= w_sel_rd;
      r_wdata <= w_sel_data;
    end
  end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Self-checking bench for gpr_wb_ctrl: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model of the writeback rules.
module tb_gpr_wb_ctrl;

  localparam int DEPTH = 2;
  localparam int XLEN  = 64;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_wdata;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_wdata;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            reg_wen;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_wdata;
  logic [$clog2(DEPTH):0] pending_cnt;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            q[$];
  logic [31:0]     mbusy;
  logic            mwen;
  logic [4:0]      mrd;
  logic [XLEN-1:0] mdata;

  int checks = 0;
  int errors = 0;

  gpr_wb_ctrl #(.FIFO_DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .reg_wen(reg_wen), .rd(rd), .rd_wdata(rd_wdata), .pending_cnt(pending_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_wdata = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  // One clock cycle: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    ent_t        e;
    ent_t        ne;
    bit          acc;
    bit          wr;
    bit          popped;
    bit          byp;
    logic [4:0]  wrd;
    logic [63:0] wd;
    logic [31:0] nb;
    #1;
    chk("lsu_ready", 64'(lsu_ready), 64'(q.size() < DEPTH));
    chk("pending_cnt", 64'(pending_cnt), 64'(q.size()));
    chk("rs1_busy", 64'(rs1_busy), 64'(mbusy[rs1]));
    chk("rs2_busy", 64'(rs2_busy), 64'(mbusy[rs2]));
    acc = lsu_valid && (q.size() < DEPTH);
    wr = 0; popped = 0; byp = 0; wrd = 0; wd = 0; nb = mbusy;
    if (alu_valid) begin
      wr = 1; wrd = alu_rd; wd = alu_wdata;
    end else if (q.size() > 0) begin
      e = q[0];
      wr = 1; wrd = e.rd; wd = e.data; nb[e.rd] = 0; popped = 1;
    end
`ifdef GPR_WB_BYPASS_EN
    else if (acc) begin
      wr = 1; wrd = lsu_rd; wd = lsu_wdata; nb[lsu_rd] = 0; byp = 1;
    end
`endif
    if (issue_valid && issue_rd != 0) nb[issue_rd] = 1;
    nb[0] = 0;
    ne.rd = lsu_rd; ne.data = lsu_wdata;
    @(posedge clock);
    #1;
    if (popped) void'(q.pop_front());
    if (acc && !byp) q.push_back(ne);
    mbusy = nb;
    mwen = wr && (wrd != 0);
    if (wr) begin
      mrd = wrd; mdata = wd;
    end
    chk("reg_wen", 64'(reg_wen), 64'(mwen));
    chk("rd", 64'(rd), 64'(mrd));
    chk("rd_wdata", rd_wdata, mdata);
  endtask

  // Asynchronous reset with random inputs held, released at a falling edge.
  task automatic rst();
    reset_n = 0;
    q.delete(); mbusy = 0; mwen = 0; mrd = 0; mdata = 0;
    #1;
    chk("rst_async_pend", 64'(pending_cnt), 64'd0);
    chk("rst_async_ready", 64'(lsu_ready), 64'd1);
    chk("rst_async_busy", 64'(rs1_busy), 64'd0);
    alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_wdata = {$urandom, $urandom};
    lsu_valid = 1'($urandom); lsu_rd = 5'($urandom); lsu_wdata = {$urandom, $urandom};
    issue_valid = 1'($urandom); issue_rd = 5'($urandom);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_wen", 64'(reg_wen), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_wdata", rd_wdata, 64'd0);
    chk("rst_ready", 64'(lsu_ready), 64'd1);
    chk("rst_pend", 64'(pending_cnt), 64'd0);
    @(negedge clock);
    reset_n = 1;
    idle();
  endtask

  initial begin
    reset_n = 0;
    idle();
    rs1 = 0; rs2 = 0;
    rst();

    // ALU path, including the x0 filter
    alu_valid = 1; alu_rd = 5; alu_wdata = 64'h1234;
    cycle();
    chk("alu_wen", 64'(reg_wen), 64'd1);
    chk("alu_rd", 64'(rd), 64'd5);
    chk("alu_data", rd_wdata, 64'h1234);
    alu_rd = 0; alu_wdata = 64'h4321;
    cycle();
    chk("alu_x0_wen", 64'(reg_wen), 64'd0);
    idle();
    cycle();

    // Contention: LSU result for r7 waits behind four ALU writes
    rs1 = 7; rs2 = 0;
    issue_valid = 1; issue_rd = 7;
    cycle();
    idle();
    alu_valid = 1; alu_rd = 1; alu_wdata = 64'h11;
    lsu_valid = 1; lsu_rd = 7; lsu_wdata = 64'hAA;
    cycle();
    lsu_valid = 0;
    for (int k = 2; k <= 4; k++) begin
      alu_rd = 5'(k); alu_wdata = 64'(k * 16 + k);
      #1;
      chk("cont_pend", 64'(pending_cnt), 64'd1);
      chk("cont_busy", 64'(rs1_busy), 64'd1);
      cycle();
    end
    idle();
    #1;
    chk("cont_pend_last", 64'(pending_cnt), 64'd1);
    cycle();
    chk("cont_lsu_wen", 64'(reg_wen), 64'd1);
    chk("cont_lsu_rd", 64'(rd), 64'd7);
    chk("cont_lsu_data", rd_wdata, 64'hAA);
    chk("cont_busy_clear", 64'(rs1_busy), 64'd0);
    cycle();

    // Full FIFO back-pressure, then in-order drain
    rs1 = 10; rs2 = 11;
    issue_valid = 1; issue_rd = 10;
    cycle();
    issue_rd = 11;
    cycle();
    idle();
    alu_valid = 1; alu_rd = 2; alu_wdata = 64'h22;
    lsu_valid = 1; lsu_rd = 10; lsu_wdata = 64'h111;
    cycle();
    lsu_rd = 11; lsu_wdata = 64'h222;
    cycle();
    lsu_valid = 0;
    #1;
    chk("full_ready", 64'(lsu_ready), 64'd0);
    chk("full_pend", 64'(pending_cnt), 64'd2);
    cycle();
    idle();
    cycle();
    chk("drain0_rd", 64'(rd), 64'd10);
    chk("drain0_ready", 64'(lsu_ready), 64'd1);
    cycle();
    chk("drain1_rd", 64'(rd), 64'd11);
    chk("drain1_data", rd_wdata, 64'h222);
    cycle();

    // Scoreboard race: re-issue r9 in the cycle its old result pops
    rs1 = 9;
    issue_valid = 1; issue_rd = 9;
    cycle();
    idle();
    alu_valid = 1; alu_rd = 3; alu_wdata = 64'h33;
    lsu_valid = 1; lsu_rd = 9; lsu_wdata = 64'h99;
    cycle();
    idle();
    issue_valid = 1; issue_rd = 9;
    cycle();
    chk("race_rd", 64'(rd), 64'd9);
    chk("race_busy", 64'(rs1_busy), 64'd1);
    idle();
    cycle();

`ifdef GPR_WB_BYPASS_EN
    lsu_valid = 1; lsu_rd = 3; lsu_wdata = 64'h55;
    cycle();
    chk("byp_wen", 64'(reg_wen), 64'd1);
    chk("byp_rd", 64'(rd), 64'd3);
    chk("byp_pend", 64'(pending_cnt), 64'd0);
    idle();
    cycle();
`endif

    // Reset in the middle of a drain
    rs1 = 12;
    issue_valid = 1; issue_rd = 12;
    cycle();
    idle();
    alu_valid = 1; alu_rd = 4; alu_wdata = 64'h44;
    lsu_valid = 1; lsu_rd = 12; lsu_wdata = 64'hC1;
    cycle();
    lsu_rd = 13; lsu_wdata = 64'hC2;
    cycle();
    idle();
    cycle();
    #2;
    rst();

    // Random traffic against the model, with one reset part way through
    for (int i = 0; i < 600; i++) begin
      if (i == 300) rst();
      alu_valid   = ($urandom_range(0, 2) == 0);
      alu_rd      = 5'($urandom);
      alu_wdata   = {$urandom, $urandom};
      lsu_valid   = ($urandom_range(0, 1) == 0);
      lsu_rd      = 5'($urandom);
      lsu_wdata   = {$urandom, $urandom};
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom);
      rs1         = 5'($urandom);
      rs2         = 5'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_wb_ctrl.md
# gpr_wb_ctrl

Writeback controller that drives the general-purpose register file's single write port (`reg_wen`/`rd`/`rd_wdata`), merging single-cycle ALU results with long-latency LSU/MDU results. LSU results are buffered in a small FIFO and drained when the ALU is not writing. A 32-entry busy scoreboard tracks destinations of in-flight long-latency ops for the decoder's RAW/WAW stall logic. It sits between execute/LSU and the register file, and is the writer-side counterpart of the register file.

## Interface

Parameters:
- `FIFO_DEPTH`, default 2: LSU result buffer depth; power of two, ≥2.
- `XLEN`, default 64: data width.

Ports:
- `clock` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `alu_valid` in 1: ALU result valid this cycle; always accepted.
- `alu_rd` in 5: ALU destination register.
- `alu_wdata` in XLEN: ALU result.
- `lsu_valid` in 1: long-latency result valid.
- `lsu_ready` out 1: buffer can accept; `= !full`.
- `lsu_rd` in 5: long-latency destination register.
- `lsu_wdata` in XLEN: long-latency result.
- `issue_valid` in 1: a long-latency op issues this cycle.
- `issue_rd` in 5: destination of the issuing op.
- `rs1`, `rs2` in 5 each: scoreboard query addresses.
- `rs1_busy`, `rs2_busy` out 1 each: combinational `busy[rs1]`, `busy[rs2]`.
- `reg_wen` out 1: register-file write enable (registered).
- `rd` out 5: register-file write address (registered).
- `rd_wdata` out XLEN: register-file write data (registered).
- `pending_cnt` out clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation

- LSU handshake: an entry enqueues at the edge where `lsu_valid && lsu_ready`. `lsu_ready` is low when full, even if a pop happens in the same cycle (no pass-through when full).
- Write-port select each cycle, in priority order:
  1. `alu_valid`: ALU result goes to the output registers.
  2. FIFO non-empty: pop the head to the output registers.
  3. Otherwise no write: `reg_wen <= 0`; `rd` and `rd_wdata` hold their values.
- x0 filter: if the selected rd is 0, `reg_wen <= 0`. A FIFO entry with rd 0 is still popped.
- ALU has strict priority. Sustained ALU traffic starves the FIFO; back-pressure via `lsu_ready` is the only relief.
- Scoreboard `busy[31:0]`:
  - `issue_valid` sets `busy[issue_rd]`; issue_rd 0 is ignored.
  - A FIFO pop clears `busy[popped rd]`.
  - Set and clear of the same index in the same cycle: set wins.
  - `busy[0]` is always 0.
- No WAW/RAW checking is done in this block. The decoder stalls on `rsN_busy` and on busy destination registers.
- Pointers wrap modulo FIFO_DEPTH. `pending_cnt` runs 0..FIFO_DEPTH. Simultaneous push and pop leaves the count unchanged.

## Timing

- Reset (async assert, sync release), all outputs and state:
  - `reg_wen`=0, `rd`=0, `rd_wdata`=0.
  - FIFO empty, `pending_cnt`=0, `lsu_ready`=1.
  - `busy`=0, so `rs1_busy`/`rs2_busy`=0.
- Reset asserted mid-operation discards buffered entries and busy bits immediately.
- ALU latency: `alu_valid` in cycle N → `reg_wen` in cycle N+1.
- LSU latency with no ALU contention: handshake in cycle N → pop in N+1 → `reg_wen` in N+2.
- `busy` clears at the same edge that registers the pop. A query in that next cycle already reads 0, matching the register file holding the new value at the following edge.

## Configuration

- `GPR_WB_BYPASS_EN` defined:
  - When the FIFO is empty, `alu_valid`=0 and the LSU handshakes, the result goes straight to the output registers and is not enqueued.
  - LSU latency becomes 1 cycle, and busy clears at that edge.
- Undefined: all LSU results pass through the FIFO, with a minimum latency of 2 cycles.

## Test plan

- Reset: hold `reset_n`=0 with random inputs → `reg_wen`=0, `rd`=0, `rd_wdata`=0, `lsu_ready`=1, `pending_cnt`=0. Assert reset mid-drain → FIFO empties and busy clears asynchronously.
- ALU path: `alu_valid`, rd=5, data=0x1234 at cycle N → `reg_wen`=1, `rd`=5, `rd_wdata`=0x1234 at N+1. Same stimulus with rd=0 → `reg_wen`=0.
- Contention:
  - Stimulus: issue rd=7; LSU result (7, 0xAA) at cycle N; ALU writes continuously N..N+3.
  - Required: `pending_cnt`=1 and `busy[7]`=1 during N+1..N+4; LSU write at N+5; `rs1_busy` for rs1=7 is 0 at N+5.
- Full/back-pressure (FIFO_DEPTH=2, ALU busy):
  - Stimulus: push two LSU results with ALU writing every cycle.
  - Required: `lsu_ready`=0. Drop `alu_valid` → one pop per cycle, in order; `lsu_ready` returns to 1 one cycle after the first pop.
- Scoreboard race: `issue_valid` rd=9 in the same cycle as a pop of rd=9 → `busy[9]` remains 1.
- Bypass (`GPR_WB_BYPASS_EN` defined): LSU handshake (3, 0x55) with FIFO empty and no ALU at cycle N → `reg_wen`=1, `rd`=3 at N+1; `pending_cnt` stays 0.
